// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants and squarer state type
package fp_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_MAN_W = 23;
  localparam int FP_EXP_W = 8;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } sq_state_e;

endpackage

// File: rtl/fp_mant_mul_seq.sv
// rtl/fp_mant_mul_seq.sv - 24x24 radix-2 shift-add mantissa squarer, one bit per cycle
module fp_mant_mul_seq
  import fp_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FP_MAN_W:0]       mcand,
  output logic                    done,
  output logic [2*FP_MAN_W+1:0]   prod
);

  logic [FP_MAN_W:0] m_q;
  logic [4:0]        cnt_q;
  logic              busy_q;

  // done marks the final add cycle; the full product is visible the cycle after
  assign done = busy_q && (cnt_q == 5'd23);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      prod   <= '0;
    end else if (start) begin
      m_q    <= mcand;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      prod   <= '0;
    end else if (busy_q) begin
      if (m_q[cnt_q])
        prod <= prod + ({{(FP_MAN_W+1){1'b0}}, m_q} << cnt_q);
      if (cnt_q == 5'd23)
        busy_q <= 1'b0;
      else
        cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/fp_square_seq.sv
// rtl/fp_square_seq.sv - multi-cycle IEEE-754 single squarer; FP_SQUARE_SEQ_ROUND_EN selects RNE over truncation
module fp_square_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_sq,
  output logic        ovf,
  output logic        unf
);

  sq_state_e                state_q;
  logic [FP_EXP_W-1:0]      exp_q;
  logic [2*FP_MAN_W+1:0]    prod;
  logic                     mul_done;
  logic                     accept;
  logic [FP_EXP_W-1:0]      a_exp;
  logic [FP_MAN_W-1:0]      a_man;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign a_exp     = A[30:23];
  assign a_man     = A[22:0];

  fp_mant_mul_seq u_mul (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .mcand ({1'b1, a_man}),
    .done  (mul_done),
    .prod  (prod)
  );

  logic signed [9:0]     e_base;
  logic signed [9:0]     e_norm;
  logic signed [9:0]     e_fin;
  logic [FP_MAN_W-1:0]   mant_sel;
  logic [FP_MAN_W:0]     mant_rnd;
  logic [FP_MAN_W-1:0]   mant_fin;
  logic                  round_up;
  logic [31:0]           norm_f;
  logic                  norm_ovf;
  logic                  norm_unf;

`ifdef FP_SQUARE_SEQ_ROUND_EN
  logic guard;
  logic sticky;
  logic unused_bits;
  assign unused_bits = A[31];
`else
  logic unused_bits;
  // truncation never looks below the kept mantissa
  assign unused_bits = ^{A[31], prod[22:0]};
`endif

  always_comb begin
    e_base   = $signed({1'b0, exp_q, 1'b0}) - 10'sd127;
    mant_sel = prod[47] ? prod[46:24] : prod[45:23];
    e_norm   = prod[47] ? e_base + 10'sd1 : e_base;
`ifdef FP_SQUARE_SEQ_ROUND_EN
    guard    = prod[47] ? prod[23] : prod[22];
    sticky   = prod[47] ? |prod[22:0] : |prod[21:0];
    round_up = guard && (sticky || mant_sel[0]);
`else
    round_up = 1'b0;
`endif
    mant_rnd = {1'b0, mant_sel} + {{FP_MAN_W{1'b0}}, round_up};
    if (mant_rnd[FP_MAN_W]) begin
      mant_fin = '0;
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_rnd[FP_MAN_W-1:0];
      e_fin    = e_norm;
    end
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (e_fin >= 10'sd255) begin
      norm_f   = FP_POS_INF;
      norm_ovf = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      norm_f   = FP_ZERO;
      norm_unf = 1'b1;
    end else begin
      norm_f = {1'b0, e_fin[7:0], mant_fin};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      f_sq    <= FP_ZERO;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            exp_q <= a_exp;
            // zero, denormal, inf and NaN bypass the multiplier entirely
            if (a_exp == '0) begin
              f_sq    <= FP_ZERO;
              ovf     <= 1'b0;
              unf     <= 1'b0;
              state_q <= ST_DONE;
            end else if (a_exp == '1) begin
              f_sq    <= (a_man == '0) ? FP_POS_INF : FP_QNAN;
              ovf     <= 1'b0;
              unf     <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (mul_done)
            state_q <= ST_NORM;
        end
        ST_NORM: begin
          f_sq    <= norm_f;
          ovf     <= norm_ovf;
          unf     <= norm_unf;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_square_seq.sv
// tb/tb_fp_square_seq.sv - scoreboard bench for fp_square_seq
module tb_fp_square_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_sq;
  logic        ovf;
  logic        unf;

  always #5 clk = ~clk;

  fp_square_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_sq      (f_sq),
    .ovf       (ovf),
    .unf       (unf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] f;
    logic        o;
    logic        u;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_sq(input logic [31:0] a);
    exp_t        r;
    logic [47:0] m48;
    logic [47:0] p;
    logic [22:0] mant;
    int          e;
    r.a = a; r.o = 1'b0; r.u = 1'b0; r.lat = 26;
    if (a[30:23] == 8'd0) begin
      r.f = 32'h0; r.lat = 1;
    end else if (a[30:23] == 8'hFF) begin
      r.f = (a[22:0] == 23'd0) ? 32'h7F800000 : 32'h7FC00000; r.lat = 1;
    end else begin
      m48 = {24'd0, 1'b1, a[22:0]};
      p   = m48 * m48;
      e   = 2 * int'(a[30:23]) - 127;
      if (p[47]) begin
        mant = p[46:24]; e = e + 1;
      end else begin
        mant = p[45:23];
      end
`ifdef FP_SQUARE_SEQ_ROUND_EN
      begin
        logic g, s;
        g = p[47] ? p[23] : p[22];
        s = p[47] ? (|p[22:0]) : (|p[21:0]);
        if (g && (s || mant[0])) begin
          if (mant == 23'h7FFFFF) begin mant = 23'd0; e = e + 1; end
          else mant = mant + 23'd1;
        end
      end
`endif
      if (e >= 255) begin r.f = 32'h7F800000; r.o = 1'b1; end
      else if (e <= 0) begin r.f = 32'h0; r.u = 1'b1; end
      else r.f = {1'b0, 8'(e), mant};
    end
    return r;
  endfunction

  // Drive one operand, then wait for and score its result.
  task automatic do_op(input logic [31:0] a, input bit use_model, input logic [31:0] fx,
                       input logic ox, input logic ux, input bit stray, input int hold);
    exp_t e;
    int   lat;
    int   w;
    if (use_model) e = ref_sq(a);
    else begin
      e.a = a; e.f = fx; e.o = ox; e.u = ux;
      e.lat = (a[30:23] == 8'd0 || a[30:23] == 8'hFF) ? 1 : 26;
    end
    sb.push_back(e);
    out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 60) begin @(negedge clk); w++; end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      void'(sb.pop_front());
      return;
    end
    in_valid = 1'b1;
    A = a;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (stray) A = ~a; else in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    in_valid = 1'b0;
    e = sb.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    check($sformatf("f_sq[%h]", a), f_sq, e.f);
    check($sformatf("ovf[%h]", a), 32'(ovf), 32'(e.o));
    check($sformatf("unf[%h]", a), 32'(unf), 32'(e.u));
    check($sformatf("latency[%h]", a), 32'(lat), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_f_sq", f_sq, e.f);
      check("hold_flags", {30'd0, ovf, unf}, {30'd0, e.o, e.u});
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_consume", 32'(in_ready), 32'd1);
    check("out_valid_after_consume", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_f_sq", f_sq, 32'h0);
    check("reset_flags", {30'd0, ovf, unf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'h40400000, 0, 32'h41100000, 0, 0, 1, 0);
    do_op(32'hBFC00000, 0, 32'h40100000, 0, 0, 0, 0);
`ifdef FP_SQUARE_SEQ_ROUND_EN
    do_op(32'h3F800801, 0, 32'h3F801003, 0, 0, 0, 0);
`else
    do_op(32'h3F800801, 0, 32'h3F801002, 0, 0, 0, 0);
`endif
    do_op(32'h3F800800, 0, 32'h3F801000, 0, 0, 0, 0);
    do_op(32'h7F000000, 0, 32'h7F800000, 1, 0, 0, 0);
    do_op(32'h1F800000, 0, 32'h00000000, 0, 1, 0, 0);
    do_op(32'h7FC00001, 0, 32'h7FC00000, 0, 0, 0, 0);
    do_op(32'hFF800000, 0, 32'h7F800000, 0, 0, 0, 0);
    do_op(32'h00000001, 0, 32'h00000000, 0, 0, 0, 0);
    do_op(32'h40400000, 0, 32'h41100000, 0, 0, 0, 5);

    // abandon an operation mid-MUL
    in_valid = 1'b1; A = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midmul_reset_in_ready", 32'(in_ready), 32'd1);
    check("midmul_reset_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midmul_no_output", 32'(seen), 32'd0);
    do_op(32'h40400000, 0, 32'h41100000, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if (i % 4 == 0) ra[30:23] = 8'd127 + 8'($urandom_range(0, 4));
      do_op(ra, 1, 32'h0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
